// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - in-order instruction fetch ring with flush/discard; optional IFETCH_BYPASS_EN
module ifetch_buf #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        jump_en_i,
    output logic        hold_flag_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        id_ready_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2
    } slot_t;

    slot_t         state_q [DEPTH];
    logic [31:0]   addr_q  [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    discard_cnt;

    logic [3:0]    n_busy;
    logic [3:0]    n_wait;
    logic          any_full;
    logic [4:0]    occ;
    logic          issue;
    logic          fill_ok;
    logic          drop;
    logic          head_full;
    logic          bypass;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Occupancy from pre-cycle state: live slots plus responses still owed to a flushed stream
    always_comb begin
        n_busy   = 4'd0;
        n_wait   = 4'd0;
        any_full = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] != S_EMPTY) n_busy = n_busy + 4'd1;
            if (state_q[i] == S_WAIT)  n_wait = n_wait + 4'd1;
            if (state_q[i] == S_FULL)  any_full = 1'b1;
        end
        occ = {1'b0, n_busy} + {1'b0, discard_cnt};
    end

    // Request, response and decode-side handshake decisions
    always_comb begin
        issue     = !rst && !jump_en_i && (occ < 5'(DEPTH));
        fill_ok   = mem_rvalid_i && (discard_cnt == 4'd0) && (state_q[fill_ptr] == S_WAIT);
        drop      = mem_rvalid_i && (discard_cnt != 4'd0);
        head_full = (state_q[rd_ptr] == S_FULL);
`ifdef IFETCH_BYPASS_EN
        bypass    = !rst && !jump_en_i && !any_full && (fill_ptr == rd_ptr) && fill_ok;
`else
        bypass    = 1'b0 & any_full;
`endif
        hold_flag_o  = !rst && (occ >= 5'(DEPTH));
        mem_req_o    = issue;
        mem_addr_o   = pc_i;
        inst_valid_o = head_full || bypass;
        if (head_full) begin
            inst_o      = data_q[rd_ptr];
            inst_addr_o = addr_q[rd_ptr];
        end else if (bypass) begin
            inst_o      = mem_rdata_i;
            inst_addr_o = addr_q[fill_ptr];
        end else begin
            inst_o      = RESET_INST;
            inst_addr_o = 32'h0;
        end
        pop = inst_valid_o && id_ready_i && !jump_en_i && !rst;
    end

    // Slot state, pointers and discard counter; a bypassed pop overrides the fill of the same slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= S_EMPTY;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            discard_cnt <= 4'd0;
        end else if (jump_en_i) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= S_EMPTY;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            discard_cnt <= discard_cnt + n_wait - {3'b0, (fill_ok || drop)};
        end else begin
            if (issue) begin
                state_q[wr_ptr] <= S_WAIT;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (fill_ok) begin
                state_q[fill_ptr] <= S_FULL;
                fill_ptr          <= ptr_inc(fill_ptr);
            end
            if (pop) begin
                state_q[rd_ptr] <= S_EMPTY;
                rd_ptr          <= ptr_inc(rd_ptr);
            end
            if (drop) begin
                discard_cnt <= discard_cnt - 4'd1;
            end
        end
    end

    // Payload storage: address captured at issue, word captured at fill
    always_ff @(posedge clk) begin
        if (issue) begin
            addr_q[wr_ptr] <= pc_i;
        end
        if (fill_ok && !jump_en_i && !rst) begin
            data_q[fill_ptr] <= mem_rdata_i;
        end
    end

    // A response with nothing outstanding means the memory side broke the protocol
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_rvalid_i && (discard_cnt == 4'd0) && (n_wait == 4'd0)));
        end
    end

endmodule

// File: tb/tb_ifetch_buf.sv
// tb/tb_ifetch_buf.sv - scoreboard bench for ifetch_buf with PC and latency memory models
module tb_ifetch_buf;

    localparam int DEPTH = 2;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        jump_en_i;
    logic        hold_flag_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        id_ready_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] dlv_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pc_nxt = 32'h0;
    logic [31:0] jump_tgt = 32'h0;
    logic [31:0] e;

    ifetch_buf #(.DEPTH(DEPTH), .RESET_INST(32'h0000_0013)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .jump_en_i    (jump_en_i),
        .hold_flag_o  (hold_flag_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .id_ready_i   (id_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]} ^ {a[15:0], 16'h0};
    endfunction

    // PC register and memory response drivers, just after each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        pc_i = pc_nxt;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(pend[0].addr);
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
        end
    end

    // Scoreboard compare on handshake, memory acceptance, PC next-value model
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            exp_q.delete();
            pc_nxt = 32'h0;
        end else begin
            if (inst_valid_o && id_ready_i && !jump_en_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got addr %h inst %h, want no delivery", inst_addr_o, inst_o);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_addr_o !== e || inst_o !== mem_word(e)) begin
                        n_bad++;
                        $display("FAIL sb_order: got addr %h inst %h, want addr %h inst %h",
                                 inst_addr_o, inst_o, e, mem_word(e));
                    end
                end
                dlv_q.push_back(inst_addr_o);
            end
            if (mem_rvalid_i && pend.size() > 0) void'(pend.pop_front());
            if (jump_en_i) exp_q.delete();
            if (mem_req_o) begin
                pend.push_back('{mem_addr_o, cyc + lat});
                exp_q.push_back(pc_i);
            end
            pc_nxt = jump_en_i ? jump_tgt : (hold_flag_o ? pc_i : pc_i + 32'd4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        step();
        rst = 1'b1; jump_en_i = 1'b0; id_ready_i = 1'b1; lat = l;
        step();
        step();
        rst = 1'b0;
        dlv_q.delete();
    endtask

    task automatic test_reset();
        step();
        step();
        @(negedge clk);
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
        n_cmp++; if (inst_o !== 32'h13) begin n_bad++; $display("FAIL rst_inst: got %h want 00000013", inst_o); end
        n_cmp++; if (inst_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", inst_addr_o); end
        n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
        n_cmp++; if (hold_flag_o !== 1'b0) begin n_bad++; $display("FAIL rst_hold: got %b want 0", hold_flag_o); end
    endtask

    task automatic test_seq();
        do_reset(1);
        @(negedge clk);
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL seq_req0: got %b/%h want 1/0", mem_req_o, mem_addr_o); end
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL seq_valid0: got %b want 0", inst_valid_o); end
        step();
        @(negedge clk);
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin n_bad++; $display("FAIL seq_req1: got %b/%h want 1/4", mem_req_o, mem_addr_o); end
        n_cmp++; if (hold_flag_o !== 1'b0) begin n_bad++; $display("FAIL seq_hold1: got %b want 0", hold_flag_o); end
        n_cmp++; if (inst_valid_o !== BYP) begin n_bad++; $display("FAIL seq_valid1: got %b want %b", inst_valid_o, BYP); end
        step();
        @(negedge clk);
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== (BYP ? 32'h4 : 32'h0)) begin
            n_bad++; $display("FAIL seq_valid2: got %b/%h want 1/%h", inst_valid_o, inst_addr_o, BYP ? 32'h4 : 32'h0);
        end
        repeat (12) step();
        @(negedge clk);
        n_cmp++; if (dlv_q.size() < 6) begin n_bad++; $display("FAIL seq_count: got %0d want >=6", dlv_q.size()); end
    endtask

    task automatic test_lat3();
        do_reset(3);
        step();
        step();
        @(negedge clk);
        n_cmp++; if (hold_flag_o !== 1'b1 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL l3_hold: got %b/%b want 1/0", hold_flag_o, mem_req_o); end
        step();
        @(negedge clk);
        n_cmp++; if (hold_flag_o !== 1'b1) begin n_bad++; $display("FAIL l3_hold2: got %b want 1", hold_flag_o); end
        repeat (20) step();
        @(negedge clk);
        n_cmp++; if (dlv_q.size() < 4 || dlv_q[0] !== 32'h0 || dlv_q[1] !== 32'h4) begin
            n_bad++; $display("FAIL l3_order: got %0d deliveries want >=4 starting 0,4", dlv_q.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        id_ready_i = 1'b0;
        repeat (4) step();
        @(negedge clk);
        n_cmp++; if (hold_flag_o !== 1'b1 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL bp_hold: got %b/%b want 1/0", hold_flag_o, mem_req_o); end
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== mem_word(32'h0)) begin
            n_bad++; $display("FAIL bp_head: got %b/%h/%h want 1/0/%h", inst_valid_o, inst_addr_o, inst_o, mem_word(32'h0));
        end
        step();
        id_ready_i = 1'b1;
        repeat (6) step();
        @(negedge clk);
        n_cmp++; if (dlv_q.size() < 2 || dlv_q[0] !== 32'h0 || dlv_q[1] !== 32'h4) begin
            n_bad++; $display("FAIL bp_drain: got %0d deliveries want >=2 starting 0,4", dlv_q.size());
        end
    endtask

    task automatic test_jump();
        do_reset(3);
        step();
        step();
        jump_en_i = 1'b1; jump_tgt = 32'h100;
        step();
        jump_en_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL jmp_valid: got %b want 0", inst_valid_o); end
        n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL jmp_discard2: got req %b want 0", mem_req_o); end
        step();
        @(negedge clk);
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin n_bad++; $display("FAIL jmp_req: got %b/%h want 1/100", mem_req_o, mem_addr_o); end
        repeat (12) step();
        @(negedge clk);
        n_cmp++; if (dlv_q.size() == 0 || dlv_q[0] !== 32'h100) begin n_bad++; $display("FAIL jmp_first: got %0d deliveries want first 100", dlv_q.size()); end
        foreach (dlv_q[i]) begin
            n_cmp++; if (dlv_q[i] < 32'h100) begin n_bad++; $display("FAIL jmp_stale: got addr %h want >=100", dlv_q[i]); end
        end
    endtask

    task automatic test_jump_rvalid();
        do_reset(2);
        step();
        step();
        jump_en_i = 1'b1; jump_tgt = 32'h200;
        step();
        jump_en_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin n_bad++; $display("FAIL jr_req: got %b/%h want 1/200", mem_req_o, mem_addr_o); end
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL jr_valid: got %b want 0", inst_valid_o); end
        repeat (10) step();
        @(negedge clk);
        n_cmp++; if (dlv_q.size() == 0 || dlv_q[0] !== 32'h200) begin n_bad++; $display("FAIL jr_first: got %0d deliveries want first 200", dlv_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        id_ready_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        n_cmp++; if (inst_valid_o !== 1'b1 || hold_flag_o !== 1'b1) begin n_bad++; $display("FAIL rm_pre: got %b/%b want 1/1", inst_valid_o, hold_flag_o); end
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h13) begin n_bad++; $display("FAIL rm_out: got %b/%h want 0/00000013", inst_valid_o, inst_o); end
        n_cmp++; if (mem_req_o !== 1'b0 || hold_flag_o !== 1'b0) begin n_bad++; $display("FAIL rm_ctl: got %b/%b want 0/0", mem_req_o, hold_flag_o); end
        step();
        rst = 1'b0; id_ready_i = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b1; jump_en_i = 1'b0; id_ready_i = 1'b1;
        pc_i = 32'h0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        test_reset();
        test_seq();
        test_lat3();
        test_backpressure();
        test_jump();
        test_jump_rvalid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
